// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core types, widths and opcode constants
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection and alignment check
module next_pc_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            en_branch,
    input  logic            jump,
    input  logic            jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rs1_val + imm;

    // jalr outranks jump/branch even if decode asserts several flags
    always_comb begin
        next_pc = pc + XLEN'(4);
        if (jalr) begin
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (jump || en_branch) begin
            next_pc = pc + imm;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, instruction register and retire counter
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_unit_if.master     imem,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    input  logic             retire,
    input  logic             en_branch,
    input  logic             jump,
    input  logic             jalr,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_val,
    output logic             fetch_fault,
    output logic [31:0]      retired_count
);

    import cpu_pkg::*;

    fetch_state_t    state;
    logic            req_q;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
        .pc         (pc),
        .imm        (imm),
        .rs1_val    (rs1_val),
        .en_branch  (en_branch),
        .jump       (jump),
        .jalr       (jalr),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            pc_plus4      <= RESET_PC + XLEN'(4);
            instr         <= NOP_INSTR;
            instr_valid   <= 1'b0;
            req_q         <= 1'b1;
            fetch_fault   <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_rvalid) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        req_q       <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        retired_count <= retired_count + 32'd1;
                        instr_valid   <= 1'b0;
                        // a misaligned target leaves pc pointing at the faulting instruction
                        if (misaligned) begin
                            fetch_fault <= 1'b1;
                            state       <= FAULT;
                        end else begin
                            pc       <= next_pc;
                            pc_plus4 <= next_pc + XLEN'(4);
                            req_q    <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_fault <= 1'b1;
                    state       <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding decode and the control unit in the single-cycle RISC-V core. Holds the PC, issues one instruction-memory request at a time, and presents the fetched instruction to decode until execute retires it. On retire it computes the next PC from the decoded branch/jump flags and enters a sticky fault state on a misaligned target.

## Interface
- `XLEN`, default 32: address and data width.
- `RESET_PC`, default 32'h0000_0000: first fetch address; must be 4-byte aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `imem_req` out 1: fetch request, held while waiting for a response.
- `imem_addr` out XLEN: fetch address, equal to `pc`.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: response instruction word.
- `instr` out 32: instruction register, driven to decode; `instr[6:0]` is the control-unit opcode.
- `instr_valid` out 1: `instr` is valid and awaiting retire.
- `pc` out XLEN: address of `instr`.
- `pc_plus4` out XLEN: `pc + 4`, link value for JAL/JALR.
- `retire` in 1: execute has finished the current instruction.
- `en_branch`, `jump`, `jalr` in 1 each: taken-branch, JAL and JALR flags from the control unit.
- `imm` in XLEN: sign-extended immediate of the current instruction.
- `rs1_val` in XLEN: rs1 operand, used for JALR.
- `fetch_fault` out 1: sticky misaligned-target fault.
- `retired_count` out 32: count of retired instructions.

## Operation
- FSM states: FETCH, EXEC, FAULT.
- **FETCH**
  - `imem_req` = 1 and `imem_addr` = `pc`, both stable until the response arrives.
  - On `imem_rvalid`: `instr` <= `imem_rdata`; next state EXEC.
- **EXEC**
  - `instr_valid` = 1 and `imem_req` = 0.
  - On `retire`, the next PC is chosen by priority:
    - `jalr`: (`rs1_val` + `imm`) & ~1.
    - else `jump` or `en_branch`: `pc` + `imm`.
    - else: `pc` + 4.
  - Only one of the three flags is set for a legal instruction; the priority order is normative regardless.
  - If next PC bits [1:0] != 0: `pc` holds, `fetch_fault` <= 1, next state FAULT.
  - Otherwise: `pc` <= next PC, next state FETCH.
  - Either way, `retired_count` increments, wrapping modulo 2^32.
- **FAULT**
  - `imem_req` = 0 and `instr_valid` = 0.
  - Exit only through reset.
- Ignored inputs:
  - `retire` in FETCH or FAULT.
  - `imem_rvalid` in EXEC or FAULT.
- All address arithmetic is modulo 2^XLEN; wrap-around past 0xFFFF_FFFC goes to 0 with no fault.

## Timing
- Reset values:
  - state FETCH, `pc` = `RESET_PC`, `instr` = 32'h0000_0013 (NOP).
  - `instr_valid` = 0, `fetch_fault` = 0, `retired_count` = 0.
  - `imem_req` = 1 in the first cycle after reset.
- Latency:
  - `imem_rvalid` in FETCH cycle N gives `instr_valid` = 1 in cycle N+1.
  - `retire` in cycle M gives `imem_req` with the new `pc` in cycle M+1.
  - Minimum 2 cycles per instruction.
- `imem_rvalid` in the same cycle `imem_req` first rises (zero-wait memory) is legal.
- Reset mid-operation takes priority over every event in that cycle.
- Instruction memory shares `rst_n` and discards any outstanding request on reset; a response after reset belongs to `RESET_PC`.
- `pc`, `pc_plus4` and `instr` are registered and constant throughout EXEC.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN`.
  - FSM state enum `fetch_state_t`.
  - `NOP_INSTR` = 32'h0000_0013.
  - Opcode constants, so decode and fetch share one definition.
- One sub-module, `next_pc_calc`, which is combinational:
  - Inputs: `pc`, `imm`, `rs1_val` and the three flags.
  - Outputs: `next_pc` and `misaligned`.
- `fetch_unit` itself holds the FSM, PC register, instruction register and counter.

## Test plan
- **Reset and first fetch:** release `rst_n` with `RESET_PC` = 0 and rvalid after 3 wait cycles with rdata = 32'h0050_0093 -> `imem_req` high and `imem_addr` = 0 for 4 cycles, then `instr` = 32'h0050_0093 with `instr_valid` = 1; `retired_count` = 0.
- **Sequential flow:** with zero-wait memory, retire with no flags 3 times -> `pc` goes 0, 4, 8, 12 at 2 cycles per instruction; `retired_count` = 3.
- **Branch and JAL:** at `pc` = 0x100, retire with `en_branch` = 1 and `imm` = -8 -> next fetch at 0xF8. Then retire with `jump` = 1 and `imm` = 0x20 -> fetch at 0x118, and `pc_plus4` = 0xFC during the JAL.
- **JALR, priority and wrap:** `rs1_val` = 0x201, `imm` = 0, `jalr` = `jump` = 1 -> fetch at 0x200. Then at `pc` = 0xFFFF_FFFC, plain retire -> `pc` = 0 with no fault.
- **Fault:** `en_branch` = 1 with `imm` = 2 at `pc` = 0x40 -> `fetch_fault` = 1 and `pc` stays 0x40; `imem_req` stays 0 for 10 cycles despite `retire`/`rvalid` pulses; `retired_count` is incremented once.
- **Reset mid-fetch:** assert `rst_n` low while waiting in FETCH at 0x80 -> next cycle `pc` = `RESET_PC`, `instr` = NOP, `instr_valid` = 0, `fetch_fault` = 0, `retired_count` = 0.
